instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage of the single-cycle CPU. It holds the PC, stores the program in a byte-addressed instruction memory that is loaded before the run, and presents the current instruction and its decoded fields to the control unit. It consumes the control unit's PCWre/PCSrc and the sign-extended immediate to form the next PC, and tracks the load/run/halt lifecycle of the processor.

Parameters:
ADDR_W, 8, byte-address width of instruction memory (MEM_BYTES = 2**ADDR_W)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
LoadEn  input  1  write one program byte this cycle
LoadAddr  input  ADDR_W  byte address for load write
LoadData  input  8  byte to write
Start  input  1  one-cycle pulse: begin execution
PCWre  input  1  from control unit: 1 = advance PC, 0 = halt
PCSrc  input  1  from control unit: 1 = take branch
ExtImm  input  32  sign-extended 16-bit immediate
PC  output  32  current PC
Instruction  output  32  current instruction word
Opcode  output  6  Instruction[31:26]
rs  output  5  Instruction[25:21]
rt  output  5  Instruction[20:16]
rd  output  5  Instruction[15:11]
Imm16  output  16  Instruction[15:0]
Running  output  1  state == RUN
Halted  output  1  state == HALT
RetireCount  output  32  instructions retired since reset

Behaviour:
- One clock (CLK). Reset is synchronous and active-high, and it has priority over all other inputs.
- Reset values: PC = RESET_PC, state = IDLE, RetireCount = 0, Running = 0, Halted = 0. Memory contents are not cleared by Reset; the program survives reset.
- States (encoding in package): IDLE, LOAD, RUN, HALT.
  - IDLE -> LOAD on LoadEn=1 without Start.
  - IDLE/LOAD -> RUN on Start=1.
  - LOAD stays in LOAD while Start=0.
  - RUN -> HALT on an edge where PCWre=0.
  - HALT is exited only by Reset.
- Load writes:
  - Performed on the rising edge when LoadEn=1 and state is IDLE or LOAD.
  - Ignored in RUN and HALT.
  - LoadEn and Start in the same cycle: the byte is written and the state goes to RUN on that edge. The first fetch sees the written byte.
- Instruction read:
  - Combinational from PC, big-endian: mem[PC], mem[PC+1], mem[PC+2], mem[PC+3] form bits [31:24] down to [7:0].
  - Only PC[ADDR_W-1:0] is used for the read.
  - If PC[31:ADDR_W] != 0 or PC[1:0] != 0, Instruction = HALT_WORD (32'hFC00_0000, opcode 6'b111111).
  - Outside RUN, Instruction = HALT_WORD, so the control unit drives PCWre=0 and no register or memory writes.
- Next PC, updated only in RUN on an edge where PCWre=1:
  - PCSrc=0: PC <= PC + 4.
  - PCSrc=1: PC <= PC + 4 + (ExtImm << 2).
  - 32-bit modulo arithmetic; wrap-around past 32'hFFFF_FFFC is permitted and not flagged.
- PC is held in IDLE, LOAD and HALT, and in RUN when PCWre=0.
- RetireCount increments by 1 on each RUN edge with PCWre=1. It saturates at 32'hFFFF_FFFF.
- Latency: a new PC is visible the cycle after the edge; Instruction and the fields follow combinationally in the same cycle.
- Reset mid-RUN: PC returns to RESET_PC, state returns to IDLE, and the program is retained. A new Start re-runs the program from RESET_PC.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - opcode constants (OP_ADD 000000, OP_ADDI 000001, OP_SUB 000010, OP_ORI 010000, OP_AND 010001, OP_OR 010010, OP_MOVE 100000, OP_SW 100110, OP_LW 100111, OP_BEQ 110000, OP_SHL 011111, OP_HALT 111111);
  - HALT_WORD;
  - the fetch state encoding.
- One sub-module, instr_rom:
  - byte array of MEM_BYTES;
  - synchronous byte write port;
  - combinational 32-bit big-endian read port.
- PC register, FSM, next-PC adder and retire counter live in instr_fetch_unit.

Test Plan:
- Reset, then load bytes 04,22,00,05 at address 0 and Start. In RUN, Instruction=32'h0422_0005, Opcode=000001, rs=1, rt=2, Imm16=5. With PCWre=1, PCSrc=0, PC=4 after one edge and RetireCount=1.
- Branch: at PC=8 with PCWre=1, PCSrc=1, ExtImm=32'hFFFF_FFFE -> PC=32'h0000_0004 next cycle. With ExtImm=3 -> PC=32'h18.
- Halt: PCWre=0 in RUN -> Halted=1 next cycle. PC, RetireCount and Instruction=HALT_WORD all hold for 10 cycles despite toggling PCSrc/LoadEn.
- Out-of-range fetch: with ADDR_W=8, a branch to PC=32'h100 -> Instruction=32'hFC00_0000. PCWre=0 then leads to HALT.
- Simultaneous LoadEn and Start writing byte FC at address 0 -> RUN entered and Instruction[31:24]=FC. A LoadEn to address 0 during RUN leaves memory unchanged.
- Reset asserted mid-RUN at PC=12 -> PC=0 and state IDLE next cycle. Start re-fetches the original word at address 0 without reloading.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-cycle CPU: opcodes, the halt word and fetch states.
// Also holds the next-PC helper used by the fetch unit.
package cpu_defs_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_SHL  = 6'b011111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } fetch_state_t;

    // Branch target is relative to the sequential PC; all arithmetic wraps modulo 2**32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic        take_branch,
                                            input logic [31:0] ext_imm);
        logic [31:0] offset;
        offset = take_branch ? (ext_imm << 2) : 32'd0;
        return pc + 32'd4 + offset;
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Byte-addressed program memory: synchronous byte write, combinational big-endian word read.
// Contents are deliberately not reset so a loaded program survives a CPU reset.
module instr_rom
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int MEM_BYTES = 2 ** ADDR_W;

    logic [7:0]        mem_r [MEM_BYTES];
    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;
    logic [ADDR_W-1:0] addr3_s;

    // Program load port, one byte per cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Assemble the word with the lowest address in the most significant byte.
    always_comb begin
        addr1_s = rd_addr + ADDR_W'(1);
        addr2_s = rd_addr + ADDR_W'(2);
        addr3_s = rd_addr + ADDR_W'(3);
        rd_data = {mem_r[rd_addr], mem_r[addr1_s], mem_r[addr2_s], mem_r[addr3_s]};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, load/run/halt lifecycle, next-PC formation and retire counter.
// Instruction and its fields are presented combinationally from the current PC.
module instr_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [7:0]        LoadData,
    input  logic              Start,
    input  logic              PCWre,
    input  logic              PCSrc,
    input  logic [31:0]       ExtImm,
    output logic [31:0]       PC,
    output logic [31:0]       Instruction,
    output logic [5:0]        Opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       Imm16,
    output logic              Running,
    output logic              Halted,
    output logic [31:0]       RetireCount
);

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  retire_r;
    logic         running_r;
    logic         halted_r;
    logic         load_we_s;
    logic         retire_s;
    logic         fetch_ok_s;
    logic [31:0]  rom_word_s;
    logic [31:0]  instr_s;

    assign load_we_s = LoadEn && !Reset && ((state_r == ST_IDLE) || (state_r == ST_LOAD));
    assign retire_s  = (state_r == ST_RUN) && PCWre;

    instr_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk     (CLK),
        .wr_en   (load_we_s),
        .wr_addr (LoadAddr),
        .wr_data (LoadData),
        .rd_addr (pc_r[ADDR_W-1:0]),
        .rd_data (rom_word_s)
    );

    // Lifecycle next-state: Start wins over LoadEn, HALT is left only through Reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_next_s = ST_RUN;
                end else if (LoadEn) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (Start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (!PCWre) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, PC and retire counter; status flags are registered from the next state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            retire_r  <= 32'd0;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            running_r <= (state_next_s == ST_RUN);
            halted_r  <= (state_next_s == ST_HALT);
            if (retire_s) begin
                pc_r <= next_pc(pc_r, PCSrc, ExtImm);
                if (retire_r != 32'hFFFF_FFFF) begin
                    retire_r <= retire_r + 32'd1;
                end
            end
        end
    end

    // Anything not a valid in-range aligned fetch in RUN reads as HALT so the CPU stops cleanly.
    always_comb begin
        fetch_ok_s = (state_r == ST_RUN) && ((pc_r >> ADDR_W) == 32'd0) && (pc_r[1:0] == 2'b00);
        if (fetch_ok_s) begin
            instr_s = rom_word_s;
        end else begin
            instr_s = HALT_WORD;
        end
    end

    assign PC          = pc_r;
    assign Instruction = instr_s;
    assign Opcode      = instr_s[31:26];
    assign rs          = instr_s[25:21];
    assign rt          = instr_s[20:16];
    assign rd          = instr_s[15:11];
    assign Imm16       = instr_s[15:0];
    assign Running     = running_r;
    assign Halted      = halted_r;
    assign RetireCount = retire_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a behavioural model
// of the program memory, PC, lifecycle and retire count.
module tb_instr_fetch_unit;
    import cpu_defs_pkg::*;

    localparam int          ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

    logic              CLK = 1'b0;
    logic              Reset, LoadEn, Start, PCWre, PCSrc;
    logic [ADDR_W-1:0] LoadAddr;
    logic [7:0]        LoadData;
    logic [31:0]       ExtImm;
    logic [31:0]       PC, Instruction, RetireCount;
    logic [5:0]        Opcode;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       Imm16;
    logic              Running, Halted;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_mem [256];
    logic [31:0] m_pc, m_ret;
    int          m_mode;
    logic [7:0]  prog [4];
    logic [31:0] save_pc, save_ret, word;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .Start(Start), .PCWre(PCWre), .PCSrc(PCSrc), .ExtImm(ExtImm),
        .PC(PC), .Instruction(Instruction), .Opcode(Opcode), .rs(rs), .rt(rt), .rd(rd),
        .Imm16(Imm16), .Running(Running), .Halted(Halted), .RetireCount(RetireCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_instr();
        logic [7:0] a;
        if (m_mode != M_RUN) return HALT_WORD;
        if (m_pc > 32'd255 || m_pc[1:0] != 2'b00) return HALT_WORD;
        a = m_pc[7:0];
        return {m_mem[a], m_mem[a + 8'd1], m_mem[a + 8'd2], m_mem[a + 8'd3]};
    endfunction

    task automatic check_model();
        logic [31:0] e;
        e = exp_instr();
        chk("pc", PC, m_pc);
        chk("retire", RetireCount, m_ret);
        chk("running", {31'd0, Running}, (m_mode == M_RUN) ? 32'd1 : 32'd0);
        chk("halted", {31'd0, Halted}, (m_mode == M_HALT) ? 32'd1 : 32'd0);
        chk("instr", Instruction, e);
        chk("opcode", {26'd0, Opcode}, {26'd0, e[31:26]});
        chk("rs", {27'd0, rs}, {27'd0, e[25:21]});
        chk("rt", {27'd0, rt}, {27'd0, e[20:16]});
        chk("rd", {27'd0, rd}, {27'd0, e[15:11]});
        chk("imm16", {16'd0, Imm16}, {16'd0, e[15:0]});
    endtask

    // Advance the model by one edge from the currently driven inputs, then compare.
    task automatic cycle();
        logic [31:0] n_pc, n_ret;
        int          n_mode;
        n_pc = m_pc; n_ret = m_ret; n_mode = m_mode;
        if (Reset) begin
            n_pc = RESET_PC; n_ret = 32'd0; n_mode = M_IDLE;
        end else if (m_mode == M_IDLE || m_mode == M_LOAD) begin
            if (LoadEn) m_mem[LoadAddr] = LoadData;
            if (Start) n_mode = M_RUN;
            else if (LoadEn) n_mode = M_LOAD;
        end else if (m_mode == M_RUN) begin
            if (PCWre) begin
                n_pc = m_pc + 32'd4 + (PCSrc ? ExtImm * 32'd4 : 32'd0);
                if (m_ret != 32'hFFFF_FFFF) n_ret = m_ret + 32'd1;
            end else begin
                n_mode = M_HALT;
            end
        end
        @(posedge CLK);
        #1;
        m_pc = n_pc; m_ret = n_ret; m_mode = n_mode;
        check_model();
    endtask

    initial begin
        prog[0] = 8'h04; prog[1] = 8'h22; prog[2] = 8'h00; prog[3] = 8'h05;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_pc = 32'd0; m_ret = 32'd0; m_mode = M_IDLE;
        Reset = 1'b1; LoadEn = 1'b0; LoadAddr = '0; LoadData = 8'h00; Start = 1'b0;
        PCWre = 1'b0; PCSrc = 1'b0; ExtImm = 32'd0;
        cycle();
        cycle();
        chk("rst_pc", PC, RESET_PC);
        chk("rst_retire", RetireCount, 32'd0);
        Reset = 1'b0;

        for (int a = 0; a < 256; a++) begin
            LoadEn = 1'b1;
            LoadAddr = 8'(a);
            LoadData = (a < 4) ? prog[a] : 8'($urandom);
            cycle();
        end
        LoadEn = 1'b0; Start = 1'b1;
        cycle();
        Start = 1'b0;
        chk("first_instr", Instruction, 32'h0422_0005);
        chk("first_opcode", {26'd0, Opcode}, 32'd1);
        chk("first_rs", {27'd0, rs}, 32'd1);
        chk("first_rt", {27'd0, rt}, 32'd2);
        chk("first_imm", {16'd0, Imm16}, 32'd5);

        PCWre = 1'b1; PCSrc = 1'b0;
        cycle();
        chk("seq_pc", PC, 32'd4);
        chk("seq_retire", RetireCount, 32'd1);
        cycle();
        PCSrc = 1'b1; ExtImm = 32'hFFFF_FFFE;
        cycle();
        chk("branch_back_pc", PC, 32'h0000_0004);
        PCSrc = 1'b0;
        cycle();
        PCSrc = 1'b1; ExtImm = 32'd3;
        cycle();
        chk("branch_fwd_pc", PC, 32'h0000_0018);

        for (int i = 0; i < 40; i++) begin
            PCSrc = 1'($urandom_range(0, 1));
            ExtImm = 32'($urandom_range(0, 12)) - 32'd6;
            LoadEn = 1'($urandom_range(0, 1));
            LoadAddr = 8'($urandom);
            LoadData = 8'($urandom);
            cycle();
        end

        LoadEn = 1'b0; PCSrc = 1'b1;
        ExtImm = (32'h100 - m_pc - 32'd4) >> 2;
        cycle();
        chk("oor_pc", PC, 32'h0000_0100);
        chk("oor_instr", Instruction, 32'hFC00_0000);
        PCWre = 1'b0;
        cycle();
        chk("halt_flag", {31'd0, Halted}, 32'd1);
        save_pc = PC; save_ret = RetireCount;
        for (int i = 0; i < 10; i++) begin
            PCSrc = 1'(i);
            LoadEn = ~1'(i);
            PCWre = 1'($urandom_range(0, 1));
            LoadAddr = 8'd0;
            LoadData = 8'($urandom);
            cycle();
            chk("halt_pc_hold", PC, save_pc);
            chk("halt_ret_hold", RetireCount, save_ret);
            chk("halt_instr", Instruction, HALT_WORD);
        end

        LoadEn = 1'b0; PCWre = 1'b0; PCSrc = 1'b0;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0; Start = 1'b1;
        cycle();
        Start = 1'b0; PCWre = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("midrun_pc", PC, 32'd12);
        Reset = 1'b1;
        cycle();
        chk("midrun_rst_pc", PC, 32'd0);
        chk("midrun_rst_run", {31'd0, Running}, 32'd0);
        Reset = 1'b0; Start = 1'b1;
        cycle();
        Start = 1'b0;
        chk("rerun_instr", Instruction, 32'h0422_0005);

        Reset = 1'b1;
        cycle();
        Reset = 1'b0; LoadEn = 1'b1; Start = 1'b1; LoadAddr = 8'd0; LoadData = 8'hFC;
        cycle();
        LoadEn = 1'b0; Start = 1'b0;
        word = Instruction;
        chk("ldstart_run", {31'd0, Running}, 32'd1);
        chk("ldstart_byte", {24'd0, word[31:24]}, 32'h0000_00FC);
        LoadEn = 1'b1; LoadData = 8'h11; PCWre = 1'b1; PCSrc = 1'b1; ExtImm = 32'hFFFF_FFFF;
        cycle();
        word = Instruction;
        chk("runload_pc", PC, 32'd0);
        chk("runload_byte", {24'd0, word[31:24]}, 32'h0000_00FC);
        LoadEn = 1'b0; PCWre = 1'b0;
        cycle();
        chk("final_halt", {31'd0, Halted}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
